// File: rtl/l1_ctrl.sv
// Direct-mapped L1 controller: one CPU request at a time, tag lookup, read-miss refill,
// write-through with write-allocate, saturating hit/miss counters.
module l1_ctrl #(
    parameter int LINE_SIZE  = 16,
    parameter int INDEX_SIZE = 4,
    parameter int TAG_SIZE   = 2,
    parameter int WORD_SIZE  = 32,
    parameter int CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cpu_req,
    input  logic                 cpu_wr,
    input  logic [WORD_SIZE-1:0] cpu_addr,
    input  logic [WORD_SIZE-1:0] cpu_wdata,
    output logic                 cpu_ready,
    output logic [WORD_SIZE-1:0] cpu_rdata,
    output logic                 cpu_hit,
    output logic                 busy,
    output logic                 mem_req,
    output logic                 mem_wr,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic                 mem_ack,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    output logic [CNT_W-1:0]     hit_count,
    output logic [CNT_W-1:0]     miss_count
);

    // Handshakes: cpu_req is sampled only in IDLE and held by the CPU until cpu_ready;
    // mem_req is held until the cycle mem_ack is high, and that edge completes the transfer.
    typedef enum logic [2:0] {IDLE, LOOKUP, MEM_RD, MEM_WR, RESP} state_t;

    state_t state, state_next;

    logic [LINE_SIZE-1:0]  valid;
    logic [TAG_SIZE-1:0]   tags  [LINE_SIZE];
    logic [WORD_SIZE-1:0]  lines [LINE_SIZE];

    logic                  wr_q;
    logic                  hit_q;
    logic [WORD_SIZE-1:0]  addr_q;
    logic [WORD_SIZE-1:0]  wdata_q;

    logic [INDEX_SIZE-1:0] idx;
    logic [TAG_SIZE-1:0]   tag;
    logic                  hit_now;
    logic                  line_we;
    logic [WORD_SIZE-1:0]  line_wdata;
    logic                  hit_inc;
    logic                  miss_inc;

    assign tag     = addr_q[WORD_SIZE-1 -: TAG_SIZE];
    assign idx     = addr_q[WORD_SIZE-TAG_SIZE-1 -: INDEX_SIZE];
    assign hit_now = valid[idx] && (tags[idx] == tag);

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b1;
        mem_req    = 1'b0;
        mem_wr     = 1'b0;
        line_we    = 1'b0;
        line_wdata = wdata_q;
        hit_inc    = 1'b0;
        miss_inc   = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (cpu_req) state_next = LOOKUP;
            end
            LOOKUP: begin
                hit_inc  = hit_now;
                miss_inc = !hit_now;
                if (wr_q) begin
                    line_we    = 1'b1;
                    state_next = MEM_WR;
                end else if (hit_now) begin
                    state_next = RESP;
                end else begin
                    state_next = MEM_RD;
                end
            end
            MEM_RD: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    line_we    = 1'b1;
                    line_wdata = mem_rdata;
                    state_next = RESP;
                end
            end
            MEM_WR: begin
                mem_req = 1'b1;
                mem_wr  = 1'b1;
                if (mem_ack) state_next = RESP;
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request latch, response registers and counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q       <= 1'b0;
            hit_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cpu_ready  <= 1'b0;
            cpu_rdata  <= '0;
            cpu_hit    <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
            valid      <= '0;
        end else begin
            cpu_ready <= (state == RESP);
            if (state == IDLE && cpu_req) begin
                wr_q    <= cpu_wr;
                addr_q  <= cpu_addr;
                wdata_q <= cpu_wdata;
            end
            if (state == LOOKUP) begin
                hit_q <= hit_now;
                if (!wr_q && hit_now) begin
                    cpu_rdata <= lines[idx];
                    cpu_hit   <= 1'b1;
                end
            end
            if (state == MEM_RD && mem_ack) begin
                cpu_rdata <= mem_rdata;
                cpu_hit   <= 1'b0;
            end
            if (state == MEM_WR && mem_ack) begin
                cpu_rdata <= wdata_q;
                cpu_hit   <= hit_q;
            end
            if (line_we) valid[idx] <= 1'b1;
            if (hit_inc && hit_count != '1)   hit_count  <= hit_count + CNT_W'(1);
            if (miss_inc && miss_count != '1) miss_count <= miss_count + CNT_W'(1);
        end
    end

    // Tag/data storage needs no reset; valid bits gate every use
    always_ff @(posedge clk) begin
        if (line_we) begin
            tags[idx]  <= tag;
            lines[idx] <= line_wdata;
        end
    end

endmodule
